branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-side branch predictor and execute-side branch resolver for the five-stage core. It drives `PCSrc`, `TargetAddr` and `PCNextE` into the program-counter block and owns the bimodal history table. It predicts conditional branches in F, carries the prediction down the pipeline to E, and signals a redirect on mispredict. It also tracks redirects that arrive while fetch is stalled.

## Interface
Parameters:
- `BHT_ENTRIES`, default 16: number of 2-bit counters; must be a power of 2, minimum 2.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `StallF`  in  1  fetch stall from the hazard unit
- `StallD`  in  1  decode stall
- `FlushD`  in  1  decode flush
- `FlushE`  in  1  execute flush
- `PCF`  in  32  fetch PC
- `InstrF`  in  32  fetched instruction
- `PCE`  in  32  PC of the instruction in E
- `PCTargetE`  in  32  branch/JAL target computed in E
- `BranchE`  in  1  conditional branch in E
- `BranchTakenE`  in  1  resolved condition of the E branch
- `JumpE`  in  1  JAL in E (JALR is excluded and handled elsewhere)
- `PCSrc`  out  2  00 sequential, 01 predicted taken, 10 redirect
- `TargetAddr`  out  32  predicted target for `PCSrc`=01
- `PCNextE`  out  32  corrected PC for `PCSrc`=10
- `MispredictE`  out  1  redirect request to the hazard unit (flush D/E)

## Operation
- History table: `BHT_ENTRIES` 2-bit saturating counters, indexed by PC[log2(BHT_ENTRIES)+1:2].
  - Every counter resets to 01 (weakly not-taken).
- F-stage lookup (combinational from registered table state):
  - `PredTakenF` = (InstrF[6:0]==1100011) && counter[PCF idx][1].
  - `TargetAddr` = PCF + sext({InstrF[31],InstrF[7],InstrF[30:25],InstrF[11:8],1'b0}), 32-bit, wrap-around allowed.
- Prediction pipeline:
  - `PredTakenD`: 0 on reset or `FlushD`; holds on `StallD`; otherwise takes `PredTakenF`.
  - `PredTakenE`: 0 on reset or `FlushE`; otherwise takes `PredTakenD`.
- E-stage resolution:
  - mispredict = `BranchE` && (`BranchTakenE` != `PredTakenE`).
  - Corrected PC = `BranchTakenE` ? `PCTargetE` : `PCE`+4.
- Table update: on every cycle with `BranchE`=1, the counter at the PCE index increments if taken, else decrements; saturates at 11 and 00.
- `PCSrc` priority: pending redirect or mispredict (10) > `PredTakenF` (01) > 00.
- `MispredictE` = mispredict || pending.
- Pending redirect:
  - If a mispredict occurs while `StallF`=1, latch the corrected PC into `PendPC` and set `Pending`=1.
  - While `Pending`=1: `PCSrc`=10 and `PCNextE`=`PendPC`.
  - `Pending` clears on the first cycle with `StallF`=0.
  - A new mispredict during `Pending` cannot occur, because E is flushed; if it does, the newer PC overwrites `PendPC`.
- Reset outputs: `PCSrc`=00, `MispredictE`=0, `PCNextE`=0 while no branch is in E, `Pending`=0, `PendPC`=0.

## Timing
- Prediction is zero-latency: `PCSrc`/`TargetAddr` are valid in the same cycle as `PCF`/`InstrF`.
- Resolution is zero-latency in E. Redirect takes effect at the next clock edge in the program-counter block.
- Table write commits at the clock edge. A same-cycle lookup of the same index sees the old value (no bypass).
- Wrong-path fetches: two (the D and E slots), flushed by the hazard unit on `MispredictE`.
- Reset mid-operation clears `Pending`, all prediction bits and all counters asynchronously.

## Configuration
- `JAL_PREDICT_EN` defined:
  - F also predicts opcode 1101111 as always taken, `PredTakenF`=1.
  - `TargetAddr` = PCF + sext({InstrF[31],InstrF[19:12],InstrF[20],InstrF[30:21],1'b0}).
  - `JumpE` never causes a redirect.
- Not defined:
  - JAL is not predicted.
  - `JumpE`=1 forces a redirect: `PCSrc`=10, `PCNextE`=`PCTargetE`, `MispredictE`=1.

## Structure
- Shared package `skylark_pkg` holds:
  - Opcode constants `OP_BRANCH`, `OP_JAL`.
  - `PCSrc` encodings `PCSRC_SEQ`, `PCSRC_PRED`, `PCSRC_REDIR`.
  - Typedef `bht_ctr_t` (2-bit).
- Sub-module `bht`: counter array with one combinational read port, one saturating-update write port, and async reset.

## Test plan
- Reset, then `InstrF`=BEQ at `PCF`=0x40 with imm +16 → `PCSrc`=00 (counter 01), `TargetAddr`=0x50.
- Same branch resolved taken in E twice → counter 11; next fetch of 0x40 gives `PCSrc`=01, `TargetAddr`=0x50.
- `PredTakenE`=1, `BranchTakenE`=0, `PCE`=0x40 → `PCSrc`=10, `PCNextE`=0x44, `MispredictE`=1.
- Mispredict with `StallF`=1 for 3 cycles → `PCSrc` held at 10 with the latched PC; clears on the cycle after `StallF` drops.
- Counter at 00 receives a not-taken update → stays 00. Counter at 11 receives a taken update → stays 11.
- JAL at 0x100 with imm −8 → with `JAL_PREDICT_EN`: `PCSrc`=01, `TargetAddr`=0xF8. Without it: `PCSrc`=10 when it reaches E.

Source files
------------

// File: rtl/skylark_pkg.sv
// Shared definitions for the skylark core front end: opcodes, PC-select
// encodings and the 2-bit branch history counter type.
package skylark_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] PCSRC_SEQ   = 2'b00;
  localparam logic [1:0] PCSRC_PRED  = 2'b01;
  localparam logic [1:0] PCSRC_REDIR = 2'b10;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_CTR_INIT = 2'b01;

  // Saturating step: sticks at 11 on taken and at 00 on not-taken.
  function automatic bht_ctr_t bht_ctr_next(input bht_ctr_t ctr, input logic taken);
    if (taken)
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else
      return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/branch_predictor_bht.sv
// Bimodal history table: one combinational read port, one saturating-update
// write port, all counters reset asynchronously to weakly not-taken.
module bht
  import skylark_pkg::*;
#(
  parameter int ENTRIES = 16,
  localparam int IW = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] rd_idx,
  output bht_ctr_t      rd_ctr,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  logic          wr_taken
);

  bht_ctr_t table_q [ENTRIES];

  // No write-to-read bypass: a lookup in the update cycle sees the old counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= BHT_CTR_INIT;
    end else if (we) begin
      table_q[wr_idx] <= bht_ctr_next(table_q[wr_idx], wr_taken);
    end
  end

  assign rd_ctr = table_q[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side bimodal predictor and execute-side resolver with stalled-redirect
// tracking. Define JAL_PREDICT_EN to predict JAL in fetch instead of redirecting in E.
module branch_predictor
  import skylark_pkg::*;
#(
  parameter int BHT_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        FlushE,
  input  logic [31:0] PCF,
  input  logic [31:0] InstrF,
  input  logic [31:0] PCE,
  input  logic [31:0] PCTargetE,
  input  logic        BranchE,
  input  logic        BranchTakenE,
  input  logic        JumpE,
  output logic [1:0]  PCSrc,
  output logic [31:0] TargetAddr,
  output logic [31:0] PCNextE,
  output logic        MispredictE
);

  localparam int IW = $clog2(BHT_ENTRIES);

  bht_ctr_t    ctr_f;
  logic        is_branch_f;
  logic        pred_taken_f;
  logic        pred_taken_d;
  logic        pred_taken_e;
  logic        mispredict;
  logic        jump_redir;
  logic        redirect_e;
  logic        pending;
  logic [31:0] pend_pc;
  logic [31:0] corrected_pc;
  logic [31:0] b_imm;

  bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (PCF[IW+1:2]),
    .rd_ctr   (ctr_f),
    .we       (BranchE),
    .wr_idx   (PCE[IW+1:2]),
    .wr_taken (BranchTakenE)
  );

  assign is_branch_f = (InstrF[6:0] == OP_BRANCH);
  assign b_imm = {{19{InstrF[31]}}, InstrF[31], InstrF[7], InstrF[30:25], InstrF[11:8], 1'b0};

`ifdef JAL_PREDICT_EN
  logic        is_jal_f;
  logic [31:0] j_imm;
  logic        unused_jump;

  // JAL is always taken and resolved in fetch, so E never redirects on it.
  assign is_jal_f     = (InstrF[6:0] == OP_JAL);
  assign j_imm        = {{11{InstrF[31]}}, InstrF[31], InstrF[19:12], InstrF[20], InstrF[30:21], 1'b0};
  assign pred_taken_f = (is_branch_f && ctr_f[1]) || is_jal_f;
  assign TargetAddr   = PCF + (is_jal_f ? j_imm : b_imm);
  assign jump_redir   = 1'b0;
  assign unused_jump  = JumpE;
`else
  logic unused_instr;

  assign pred_taken_f = is_branch_f && ctr_f[1];
  assign TargetAddr   = PCF + b_imm;
  assign jump_redir   = JumpE;
  assign unused_instr = ^InstrF[24:12];
`endif

  // Prediction bit travels alongside its instruction so E can judge it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_taken_d <= 1'b0;
      pred_taken_e <= 1'b0;
    end else begin
      if (FlushD)
        pred_taken_d <= 1'b0;
      else if (!StallD)
        pred_taken_d <= pred_taken_f;
      pred_taken_e <= FlushE ? 1'b0 : pred_taken_d;
    end
  end

  assign mispredict = BranchE && (BranchTakenE != pred_taken_e);
  assign redirect_e = mispredict || jump_redir;

  always_comb begin
    corrected_pc = '0;
    if (BranchE)
      corrected_pc = BranchTakenE ? PCTargetE : PCE + 32'd4;
    else if (jump_redir)
      corrected_pc = PCTargetE;
  end

  // A redirect raised while fetch is stalled would be lost; hold it until fetch moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      pend_pc <= '0;
    end else if (redirect_e && StallF) begin
      pending <= 1'b1;
      pend_pc <= corrected_pc;
    end else if (!StallF) begin
      pending <= 1'b0;
    end
  end

  assign PCNextE     = pending ? pend_pc : corrected_pc;
  assign MispredictE = redirect_e || pending;
  assign PCSrc       = (pending || redirect_e) ? PCSRC_REDIR :
                       pred_taken_f            ? PCSRC_PRED  : PCSRC_SEQ;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic against a behavioural model of the predictor rules.
module tb_branch_predictor;

  localparam int BHT = 16;
`ifdef JAL_PREDICT_EN
  localparam bit JAL_PRED = 1'b1;
`else
  localparam bit JAL_PRED = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, FlushE;
  logic [31:0] PCF, InstrF, PCE, PCTargetE;
  logic        BranchE, BranchTakenE, JumpE;
  logic [1:0]  PCSrc;
  logic [31:0] TargetAddr, PCNextE;
  logic        MispredictE;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int          ctr [BHT];
  bit          m_pred_d, m_pred_e, m_pend;
  logic [31:0] m_pend_pc;

  always #5 clk = ~clk;

  branch_predictor #(.BHT_ENTRIES(BHT)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .PCF(PCF), .InstrF(InstrF),
    .PCE(PCE), .PCTargetE(PCTargetE), .BranchE(BranchE),
    .BranchTakenE(BranchTakenE), .JumpE(JumpE), .PCSrc(PCSrc),
    .TargetAddr(TargetAddr), .PCNextE(PCNextE), .MispredictE(MispredictE)
  );

  function automatic logic [31:0] enc_beq(input int imm);
    logic [12:0] i;
    i = 13'(imm);
    return {i[12], i[10:5], 5'd2, 5'd1, 3'b000, i[4:1], i[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(input int imm);
    logic [20:0] i;
    i = 21'(imm);
    return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'(BHT));
  endfunction

  function automatic bit is_jal(input logic [31:0] ins);
    return ins[6:0] == 7'h6F;
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [31:0] ins);
    int imm;
    if (JAL_PRED && is_jal(ins)) begin
      imm = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096;
      if (ins[31]) imm -= (1 << 20);
    end else begin
      imm = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048;
      if (ins[31]) imm -= 4096;
    end
    return pc + 32'(imm);
  endfunction

  function automatic bit model_pred_f();
    bit is_b;
    is_b = (InstrF[6:0] == 7'h63);
    return (is_b && ctr[idx_of(PCF)] >= 2) || (JAL_PRED && is_jal(InstrF));
  endfunction

  function automatic logic [31:0] model_corr();
    if (BranchE) return BranchTakenE ? PCTargetE : PCE + 32'd4;
    if (!JAL_PRED && JumpE) return PCTargetE;
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BHT; i++) ctr[i] = 1;
    m_pred_d = 0; m_pred_e = 0; m_pend = 0; m_pend_pc = 0;
  endtask

  task automatic model_expect(output logic [1:0] e_src, output logic [31:0] e_tgt,
                              output logic [31:0] e_next, output logic e_mis);
    bit mis, jr;
    mis    = BranchE && (BranchTakenE != m_pred_e);
    jr     = !JAL_PRED && JumpE;
    e_tgt  = model_target(PCF, InstrF);
    e_next = m_pend ? m_pend_pc : model_corr();
    e_mis  = mis || jr || m_pend;
    e_src  = e_mis ? 2'd2 : (model_pred_f() ? 2'd1 : 2'd0);
  endtask

  // next-state of the model from the inputs currently applied
  task automatic model_clock();
    bit pf, mis, jr;
    int i;
    pf  = model_pred_f();
    mis = BranchE && (BranchTakenE != m_pred_e);
    jr  = !JAL_PRED && JumpE;
    if (mis || jr) begin
      if (StallF) begin m_pend = 1; m_pend_pc = model_corr(); end
    end
    if (!StallF && !((mis || jr) && StallF)) m_pend = 0;
    if (BranchE) begin
      i = idx_of(PCE);
      if (BranchTakenE) ctr[i] = (ctr[i] < 3) ? ctr[i] + 1 : 3;
      else              ctr[i] = (ctr[i] > 0) ? ctr[i] - 1 : 0;
    end
    m_pred_e = FlushE ? 0 : m_pred_d;
    m_pred_d = FlushD ? 0 : (StallD ? m_pred_d : pf);
  endtask

  task automatic advance();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    StallF = 0; StallD = 0; FlushD = 0; FlushE = 0;
    PCF = 32'h0; InstrF = NOP; PCE = 32'h0; PCTargetE = 32'h0;
    BranchE = 0; BranchTakenE = 0; JumpE = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    model_reset();
    @(negedge clk);
    n_tests++; if (PCSrc !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_pcsrc got %b want 00", PCSrc); end
    n_tests++; if (MispredictE !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mis got %b want 0", MispredictE); end
    n_tests++; if (PCNextE !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pcnext got %h want 0", PCNextE); end
    @(negedge clk);
    reset = 1'b0;
    advance();
  endtask

  task automatic test_predict();
    PCF = 32'h40; InstrF = enc_beq(16);
    @(negedge clk);
    n_tests++; if (PCSrc !== 2'b00) begin n_fail++; $display("[TB] FAIL weak_nt_pcsrc got %b want 00", PCSrc); end
    n_tests++; if (TargetAddr !== 32'h50) begin n_fail++; $display("[TB] FAIL beq_target got %h want 50", TargetAddr); end
    advance();
    drive_idle();
    BranchE = 1; PCE = 32'h40; PCTargetE = 32'h50; BranchTakenE = 1;
    @(negedge clk); advance();
    @(negedge clk); advance();
    drive_idle();
    PCF = 32'h40; InstrF = enc_beq(16);
    @(negedge clk);
    n_tests++; if (PCSrc !== 2'b01) begin n_fail++; $display("[TB] FAIL trained_pcsrc got %b want 01", PCSrc); end
    n_tests++; if (TargetAddr !== 32'h50) begin n_fail++; $display("[TB] FAIL trained_target got %h want 50", TargetAddr); end
    advance();
  endtask

  task automatic test_mispredict();
    drive_idle();
    @(negedge clk);
    n_tests++; if (MispredictE !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_mis got %b want 0", MispredictE); end
    advance();
    BranchE = 1; PCE = 32'h40; PCTargetE = 32'h50; BranchTakenE = 0;
    @(negedge clk);
    n_tests++; if (PCSrc !== 2'b10) begin n_fail++; $display("[TB] FAIL misp_pcsrc got %b want 10", PCSrc); end
    n_tests++; if (PCNextE !== 32'h44) begin n_fail++; $display("[TB] FAIL misp_pcnext got %h want 44", PCNextE); end
    n_tests++; if (MispredictE !== 1'b1) begin n_fail++; $display("[TB] FAIL misp_flag got %b want 1", MispredictE); end
    advance();
  endtask

  task automatic test_pending_stall();
    drive_idle();
    StallF = 1; BranchE = 1; PCE = 32'h80; PCTargetE = 32'h200; BranchTakenE = 1;
    @(negedge clk);
    n_tests++; if (PCNextE !== 32'h200) begin n_fail++; $display("[TB] FAIL stall_misp_pcnext got %h want 200", PCNextE); end
    advance();
    for (int k = 0; k < 3; k++) begin
      drive_idle();
      StallF = (k < 2); PCTargetE = 32'h999;
      @(negedge clk);
      n_tests++; if (PCSrc !== 2'b10) begin n_fail++; $display("[TB] FAIL pend_pcsrc[%0d] got %b want 10", k, PCSrc); end
      n_tests++; if (PCNextE !== 32'h200) begin n_fail++; $display("[TB] FAIL pend_pcnext[%0d] got %h want 200", k, PCNextE); end
      n_tests++; if (MispredictE !== 1'b1) begin n_fail++; $display("[TB] FAIL pend_mis[%0d] got %b want 1", k, MispredictE); end
      advance();
    end
    @(negedge clk);
    n_tests++; if (PCSrc !== 2'b00) begin n_fail++; $display("[TB] FAIL pend_clear_pcsrc got %b want 00", PCSrc); end
    n_tests++; if (MispredictE !== 1'b0) begin n_fail++; $display("[TB] FAIL pend_clear_mis got %b want 0", MispredictE); end
    advance();
  endtask

  task automatic test_saturation();
    drive_idle();
    BranchE = 1; PCE = 32'h10;
    for (int k = 0; k < 4; k++) begin
      BranchTakenE = (k >= 2);
      @(negedge clk); advance();
    end
    drive_idle(); PCF = 32'h10; InstrF = enc_beq(8);
    @(negedge clk);
    n_tests++; if (PCSrc !== 2'b01) begin n_fail++; $display("[TB] FAIL sat_low_pcsrc got %b want 01", PCSrc); end
    advance();
    drive_idle(); @(negedge clk); advance(); @(negedge clk); advance();
    BranchE = 1; PCE = 32'h14; BranchTakenE = 1;
    for (int k = 0; k < 3; k++) begin @(negedge clk); advance(); end
    BranchTakenE = 0;
    @(negedge clk); advance();
    PCF = 32'h14; InstrF = enc_beq(8);
    @(negedge clk);
    n_tests++; if (PCSrc !== 2'b01) begin n_fail++; $display("[TB] FAIL no_bypass_pcsrc got %b want 01", PCSrc); end
    advance();
    BranchE = 0;
    @(negedge clk);
    n_tests++; if (PCSrc !== 2'b00) begin n_fail++; $display("[TB] FAIL sat_high_pcsrc got %b want 00", PCSrc); end
    advance();
  endtask

  task automatic test_jal();
    drive_idle(); @(negedge clk); advance(); @(negedge clk); advance();
    PCF = 32'h100; InstrF = enc_jal(-8);
    @(negedge clk);
`ifdef JAL_PREDICT_EN
    n_tests++; if (PCSrc !== 2'b01) begin n_fail++; $display("[TB] FAIL jal_f_pcsrc got %b want 01", PCSrc); end
    n_tests++; if (TargetAddr !== 32'hF8) begin n_fail++; $display("[TB] FAIL jal_f_target got %h want f8", TargetAddr); end
`else
    n_tests++; if (PCSrc !== 2'b00) begin n_fail++; $display("[TB] FAIL jal_f_pcsrc got %b want 00", PCSrc); end
`endif
    advance();
    drive_idle(); JumpE = 1; PCE = 32'h100; PCTargetE = 32'hF8;
    @(negedge clk);
`ifdef JAL_PREDICT_EN
    n_tests++; if (PCSrc !== 2'b00) begin n_fail++; $display("[TB] FAIL jal_e_pcsrc got %b want 00", PCSrc); end
    n_tests++; if (MispredictE !== 1'b0) begin n_fail++; $display("[TB] FAIL jal_e_mis got %b want 0", MispredictE); end
`else
    n_tests++; if (PCSrc !== 2'b10) begin n_fail++; $display("[TB] FAIL jal_e_pcsrc got %b want 10", PCSrc); end
    n_tests++; if (PCNextE !== 32'hF8) begin n_fail++; $display("[TB] FAIL jal_e_pcnext got %h want f8", PCNextE); end
    n_tests++; if (MispredictE !== 1'b1) begin n_fail++; $display("[TB] FAIL jal_e_mis got %b want 1", MispredictE); end
`endif
    advance();
    drive_idle(); @(negedge clk); advance(); @(negedge clk); advance();
  endtask

  task automatic test_midop_reset();
    StallF = 1; BranchE = 1; PCE = 32'h40; PCTargetE = 32'h300; BranchTakenE = !m_pred_e;
    @(negedge clk); advance();
    drive_idle(); StallF = 1; PCF = 32'h14; InstrF = enc_beq(8);
    reset = 1'b1;
    #2;
    n_tests++; if (PCSrc !== 2'b00) begin n_fail++; $display("[TB] FAIL midreset_pcsrc got %b want 00", PCSrc); end
    n_tests++; if (MispredictE !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_mis got %b want 0", MispredictE); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    advance();
  endtask

  task automatic test_random();
    logic [1:0]  e_src;
    logic [31:0] e_tgt, e_next;
    logic        e_mis;
    for (int n = 0; n < 600; n++) begin
      StallF = ($urandom_range(0, 3) == 0);
      StallD = ($urandom_range(0, 4) == 0);
      FlushD = ($urandom_range(0, 7) == 0);
      FlushE = ($urandom_range(0, 7) == 0);
      PCF = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC) : 32'($urandom_range(0, 31) * 4);
      InstrF = $urandom;
      case ($urandom_range(0, 4))
        0, 1:    InstrF[6:0] = 7'b1100011;
        2:       InstrF[6:0] = 7'b1101111;
        default: InstrF[6:0] = 7'b0110011;
      endcase
      BranchE = $urandom_range(0, 1);
      BranchTakenE = $urandom_range(0, 1);
      JumpE = !BranchE && ($urandom_range(0, 5) == 0);
      PCE = 32'($urandom_range(0, 31) * 4);
      PCTargetE = $urandom;
      @(negedge clk);
      model_expect(e_src, e_tgt, e_next, e_mis);
      n_tests++; if (PCSrc !== e_src) begin n_fail++; $display("[TB] FAIL rnd_pcsrc cyc %0d got %b want %b", n, PCSrc, e_src); end
      n_tests++; if (TargetAddr !== e_tgt) begin n_fail++; $display("[TB] FAIL rnd_target cyc %0d got %h want %h", n, TargetAddr, e_tgt); end
      n_tests++; if (PCNextE !== e_next) begin n_fail++; $display("[TB] FAIL rnd_pcnext cyc %0d got %h want %h", n, PCNextE, e_next); end
      n_tests++; if (MispredictE !== e_mis) begin n_fail++; $display("[TB] FAIL rnd_mis cyc %0d got %b want %b", n, MispredictE, e_mis); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_predict();
    test_mispredict();
    test_pending_stall();
    test_saturation();
    test_jal();
    test_midop_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
